// File: rtl/dual_decode_dispatch.sv
// dual_decode_dispatch
// Two-wide RV32 decode and dispatch stage. Each cycle it looks at the two
// oldest words of the instruction queue, decodes them into packed micro-ops,
// and consumes up to two of them in program order. Canonical nops are
// swallowed without taking a lane or a ROB credit. Consumed micro-ops are
// registered and presented one cycle later, compacted into lane 0 first.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   instr1/instr2  oldest / next-oldest instruction words
//   shift_count    instructions consumed this cycle (0..2), combinational
//   out_valid      per-lane valid of the registered micro-ops (bit1 => bit0)
//   out_uop0/1     {class[2:0], rd, rs1, rs2, funct3[2:0], imm[31:0]}
//   out_ready      downstream accepts both lanes this cycle
//   credit_return  ROB entries retired this cycle (0..2)
//   stat_issued    non-nop instructions issued (DISPATCH_STATS_EN only)
//   stat_stall     cycles with a real instr1 but nothing consumed
//
// Build option
//   DISPATCH_STATS_EN  when defined, the two statistics counters exist;
//                      otherwise both stat outputs are tied to zero.

module dual_decode_dispatch #(
    parameter int ROB_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr1,
    input  logic [31:0] instr2,
    output logic [1:0]  shift_count,
    output logic [1:0]  out_valid,
    output logic [52:0] out_uop0,
    output logic [52:0] out_uop1,
    input  logic        out_ready,
    input  logic [1:0]  credit_return,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
);

    localparam int          CW  = $clog2(ROB_DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Decode one instruction word into the packed micro-op format.
    function automatic logic [52:0] decode(input logic [31:0] ins);
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        cls = 3'd7;
        rd  = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        f3  = 3'd0;
        imm = 32'd0;
        case (ins[6:0])
            7'b0110011: begin
                cls = (ins[31:25] == 7'b0000001) ? 3'd5 : 3'd0;
                rd  = ins[11:7];
                rs1 = ins[19:15];
                rs2 = ins[24:20];
                f3  = ins[14:12];
            end
            7'b0010011, 7'b0000011: begin
                cls = (ins[6:0] == 7'b0010011) ? 3'd1 : 3'd2;
                rd  = ins[11:7];
                rs1 = ins[19:15];
                f3  = ins[14:12];
                imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                cls = 3'd3;
                rs1 = ins[19:15];
                rs2 = ins[24:20];
                f3  = ins[14:12];
                imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                cls = 3'd4;
                rs1 = ins[19:15];
                rs2 = ins[24:20];
                f3  = ins[14:12];
                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                cls = 3'd6;
                rd  = ins[11:7];
                imm = {ins[31:12], 12'd0};
            end
            7'b1101111: begin
                cls = 3'd6;
                rd  = ins[11:7];
                imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin
                cls = 3'd6;
                rd  = ins[11:7];
                rs1 = ins[19:15];
                f3  = ins[14:12];
                imm = {{20{ins[31]}}, ins[31:20]};
            end
            default: cls = 3'd7;
        endcase
        return {cls, rd, rs1, rs2, f3, imm};
    endfunction

    logic [CW-1:0]   credits;
    logic [CW-1:0]   credits_next;
    logic [CW+1:0]   credit_sum;
    logic [52:0]     dec1;
    logic [52:0]     dec2;
    logic [52:0]     lane0;
    logic            i1_real;
    logic            i2_real;
    logic            can_load;
    logic            take1;
    logic            take2;
    logic [1:0]      issued;
    logic [1:0]      new_valid;

    assign dec1     = decode(instr1);
    assign dec2     = decode(instr2);
    assign i1_real  = (instr1 != NOP);
    assign i2_real  = (instr2 != NOP);
    assign can_load = (out_valid == 2'b00) || out_ready;

    // Acceptance: instr2 only follows a consumed instr1. Real instructions
    // need a credit from the registered count (a same-cycle return does not
    // help) and a loadable output register; only one MULDIV per cycle.
    always_comb begin
        take1 = 1'b0;
        take2 = 1'b0;
        if (!reset) begin
            take1 = !i1_real || ((credits != '0) && can_load);
            if (take1) begin
                if (!i2_real) begin
                    take2 = 1'b1;
                end else if (can_load && (credits > CW'(i1_real)) &&
                             !(i1_real && (dec1[52:50] == 3'd5) && (dec2[52:50] == 3'd5))) begin
                    take2 = 1'b1;
                end
            end
        end
    end

    assign shift_count = 2'(take1) + 2'(take2);
    assign issued      = 2'(take1 && i1_real) + 2'(take2 && i2_real);
    assign new_valid   = (issued == 2'd2) ? 2'b11 : ((issued == 2'd1) ? 2'b01 : 2'b00);

    // With nop+real the real word is compacted into lane 0.
    assign lane0 = (take1 && i1_real) ? dec1 : dec2;

    // Credits saturate at ROB_DEPTH; issue and return apply together.
    assign credit_sum   = (CW+2)'(credits) - (CW+2)'(issued) + (CW+2)'(credit_return);
    assign credits_next = (credit_sum > (CW+2)'(ROB_DEPTH)) ? CW'(ROB_DEPTH) : credit_sum[CW-1:0];

    // Output register and credit state; the register only changes when it
    // is free or being drained, so a stalled pair stays put.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits   <= CW'(ROB_DEPTH);
            out_valid <= 2'b00;
            out_uop0  <= '0;
            out_uop1  <= '0;
        end else begin
            credits <= credits_next;
            if (can_load) begin
                out_valid <= new_valid;
                out_uop0  <= new_valid[0] ? lane0 : '0;
                out_uop1  <= new_valid[1] ? dec2 : '0;
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    logic [31:0] issued_cnt;
    logic [31:0] stall_cnt;

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            issued_cnt <= issued_cnt + 32'(issued);
            stall_cnt  <= stall_cnt + 32'(i1_real && (shift_count == 2'd0));
        end
    end

    assign stat_issued = issued_cnt;
    assign stat_stall  = stall_cnt;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_dual_decode_dispatch.sv
// Self-checking bench for dual_decode_dispatch: directed steps, expected
// output-register contents queued at drive time and checked one cycle later.

module tb_dual_decode_dispatch;

    localparam int          ROB = 16;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LD1  = 32'h00b0_2083;
    localparam logic [31:0] LD2  = 32'h00f0_2103;
    localparam logic [31:0] MUL1 = 32'h0240_8533;
    localparam logic [31:0] MUL2 = 32'h0251_05b3;
    localparam logic [31:0] ADD  = 32'h00b5_0833;
    localparam logic [31:0] SW   = 32'hFE53_2E23;
    localparam logic [31:0] BEQ  = 32'hFE20_8CE3;
    localparam logic [31:0] LUI  = 32'h1234_51B7;
    localparam logic [31:0] ILL  = 32'hFFFF_FFFF;
    localparam logic [31:0] ADDI = 32'hFFF0_0093;

    function automatic logic [52:0] mk(input int c, input int rd, input int rs1,
                                       input int rs2, input int f3, input logic [31:0] imm);
        return {3'(c), 5'(rd), 5'(rs1), 5'(rs2), 3'(f3), imm};
    endfunction

    logic        clk;
    logic        reset;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [1:0]  shift_count;
    logic [1:0]  out_valid;
    logic [52:0] out_uop0;
    logic [52:0] out_uop1;
    logic        out_ready;
    logic [1:0]  credit_return;
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;

    dual_decode_dispatch #(.ROB_DEPTH(ROB)) dut (
        .clk(clk), .reset(reset), .instr1(instr1), .instr2(instr2),
        .shift_count(shift_count), .out_valid(out_valid),
        .out_uop0(out_uop0), .out_uop1(out_uop1), .out_ready(out_ready),
        .credit_return(credit_return), .stat_issued(stat_issued), .stat_stall(stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  v;
        logic [52:0] u0;
        logic [52:0] u1;
        logic [31:0] cr;
        logic [31:0] iss;
        logic [31:0] stl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   expCredits = ROB;
    int   expIssued = 0;
    int   expStall = 0;

    logic [52:0] U_LD1, U_LD2, U_MUL1, U_MUL2, U_ADD, U_SW, U_BEQ, U_LUI, U_ILL, U_ADDI;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected stat values depend on whether the counters are built in.
    task automatic chkStats(input int iss, input int stl);
`ifdef DISPATCH_STATS_EN
        chk("stat_issued", 64'(stat_issued), 64'(iss));
        chk("stat_stall", 64'(stat_stall), 64'(stl));
`else
        chk("stat_issued", 64'(stat_issued), 64'(iss * 0));
        chk("stat_stall", 64'(stat_stall), 64'(stl * 0));
`endif
    endtask

    task automatic applyStimulus(input logic [31:0] i1, input logic [31:0] i2,
                                 input logic rdy, input logic [1:0] ret,
                                 input logic [1:0] expShift, input logic [1:0] expValid,
                                 input logic [52:0] u0, input logic [52:0] u1);
        exp_t e;
        int   iss;
        @(negedge clk);
        instr1 = i1;
        instr2 = i2;
        out_ready = rdy;
        credit_return = ret;
        #1;
        chk("shift_count", 64'(shift_count), 64'(expShift));
        iss = ((expShift >= 2'd1 && i1 != NOP) ? 1 : 0) + ((expShift == 2'd2 && i2 != NOP) ? 1 : 0);
        expCredits = expCredits - iss + int'(ret);
        if (expCredits > ROB) expCredits = ROB;
        expIssued += iss;
        if (i1 != NOP && expShift == 2'd0) expStall++;
        e.v = expValid;
        e.u0 = u0;
        e.u1 = u1;
        e.cr = 32'(expCredits);
        e.iss = 32'(expIssued);
        e.stl = 32'(expStall);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty observed 0 expected 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_valid", 64'(out_valid), 64'(e.v));
            if (e.v[0]) chk("out_uop0", 64'(out_uop0), 64'(e.u0));
            if (e.v[1]) chk("out_uop1", 64'(out_uop1), 64'(e.u1));
            chk("credits", 64'(dut.credits), 64'(e.cr));
            chkStats(int'(e.iss), int'(e.stl));
        end
    endtask

    task automatic step(input logic [31:0] i1, input logic [31:0] i2,
                        input logic rdy, input logic [1:0] ret,
                        input logic [1:0] expShift, input logic [1:0] expValid,
                        input logic [52:0] u0, input logic [52:0] u1);
        applyStimulus(i1, i2, rdy, ret, expShift, expValid, u0, u1);
        checkOutput();
    endtask

    task automatic checkResetState();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_uop0", 64'(out_uop0), 64'd0);
        chk("rst_out_uop1", 64'(out_uop1), 64'd0);
        chk("rst_credits", 64'(dut.credits), 64'(ROB));
        chkStats(0, 0);
    endtask

    initial begin
        U_LD1  = mk(2, 1, 0, 0, 2, 32'd11);
        U_LD2  = mk(2, 2, 0, 0, 2, 32'd15);
        U_MUL1 = mk(5, 10, 1, 4, 0, 32'd0);
        U_MUL2 = mk(5, 11, 2, 5, 0, 32'd0);
        U_ADD  = mk(0, 16, 10, 11, 0, 32'd0);
        U_SW   = mk(3, 0, 6, 5, 2, 32'hFFFF_FFFC);
        U_BEQ  = mk(4, 0, 1, 2, 0, 32'hFFFF_FFF8);
        U_LUI  = mk(6, 3, 0, 0, 0, 32'h1234_5000);
        U_ILL  = mk(7, 0, 0, 0, 0, 32'd0);
        U_ADDI = mk(1, 1, 0, 0, 0, 32'hFFFF_FFFF);

        $display("[TB] dual_decode_dispatch bench start");
        reset = 1'b1;
        instr1 = LD1;
        instr2 = LD2;
        out_ready = 1'b1;
        credit_return = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_shift_count", 64'(shift_count), 64'd0);
        @(posedge clk);
        #1;
        checkResetState();
        reset = 1'b0;

        // Two loads issue together.
        step(LD1, LD2, 1'b1, 2'd0, 2'd2, 2'b11, U_LD1, U_LD2);
        // Back-to-back MULDIV: one per cycle.
        step(MUL1, MUL2, 1'b1, 2'd0, 2'd1, 2'b01, U_MUL1, 53'd0);
        step(MUL2, MUL1, 1'b1, 2'd0, 2'd1, 2'b01, U_MUL2, 53'd0);
        // Nop dropped, real instruction compacted into lane 0.
        step(NOP, ADD, 1'b1, 2'd0, 2'd2, 2'b01, U_ADD, 53'd0);
        // Immediate formats and classes.
        step(SW, BEQ, 1'b1, 2'd0, 2'd2, 2'b11, U_SW, U_BEQ);
        step(LUI, ILL, 1'b1, 2'd0, 2'd2, 2'b11, U_LUI, U_ILL);
        step(ADDI, NOP, 1'b1, 2'd0, 2'd2, 2'b01, U_ADDI, 53'd0);
        step(NOP, NOP, 1'b1, 2'd0, 2'd2, 2'b00, 53'd0, 53'd0);
        // Backpressure: the loaded pair holds for three cycles.
        step(LD1, LD2, 1'b1, 2'd0, 2'd2, 2'b11, U_LD1, U_LD2);
        for (int i = 0; i < 3; i++)
            step(SW, BEQ, 1'b0, 2'd0, 2'd0, 2'b11, U_LD1, U_LD2);
        step(SW, BEQ, 1'b1, 2'd0, 2'd2, 2'b11, U_SW, U_BEQ);
        // Credit exhaustion; same-cycle return does not unblock.
        step(LD1, LD2, 1'b1, 2'd0, 2'd2, 2'b11, U_LD1, U_LD2);
        step(LD1, LD2, 1'b1, 2'd2, 2'd0, 2'b00, 53'd0, 53'd0);
        step(LD1, LD2, 1'b1, 2'd0, 2'd2, 2'b11, U_LD1, U_LD2);
        step(MUL1, LD2, 1'b1, 2'd1, 2'd0, 2'b00, 53'd0, 53'd0);
        step(LD1, LD2, 1'b1, 2'd0, 2'd1, 2'b01, U_LD1, 53'd0);
        // Returns saturate at ROB depth.
        for (int i = 0; i < 9; i++)
            step(NOP, NOP, 1'b1, 2'd2, 2'd2, 2'b00, 53'd0, 53'd0);
        // Reset in the middle of operation discards the output pair.
        step(LD1, LD2, 1'b1, 2'd0, 2'd2, 2'b11, U_LD1, U_LD2);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid_shift_count", 64'(shift_count), 64'd0);
        @(posedge clk);
        #1;
        checkResetState();
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
